// File: rtl/fmac_pkg.sv
// fmac_pkg: shared FMAC datapath constants, legal ranges and helpers
package fmac_pkg;
   localparam logic ADD_MODE_ADD = 1'b0;
   localparam logic ADD_MODE_SUB = 1'b1;
   localparam int ADD_WIDTH_MIN = 2;
   localparam int ADD_WIDTH_MAX = 64;
   localparam int ADD_STAGES_MIN = 1;
   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: combinational ripple of full adders over one carry-chain segment
module adder_segment #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   logic c;
   always_comb begin
      c = cin;
      s = '0;
      for (int i = 0; i < W; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/adder_pipe_param.sv
// adder_pipe_param: STAGES-deep pipelined ripple adder/subtractor with valid/ready;
// define ADDER_PIPE_SAT_EN to saturate s on signed overflow
module adder_pipe_param
   import fmac_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int SEG = ceil_div(WIDTH, STAGES);

   if (WIDTH < ADD_WIDTH_MIN || WIDTH > ADD_WIDTH_MAX) begin : g_bad_width
      $error("adder_pipe_param: WIDTH out of range");
   end
   if (STAGES < ADD_STAGES_MIN || STAGES > WIDTH) begin : g_bad_stages
      $error("adder_pipe_param: STAGES out of range");
   end

   logic             en;
   logic [WIDTH-1:0] a_i [STAGES];
   logic [WIDTH-1:0] b_i [STAGES];
   logic [WIDTH-1:0] s_i [STAGES];
   logic             c_i [STAGES];
   logic             v_i [STAGES];
   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_d [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_d [STAGES];
   logic             c_q [STAGES];
   logic             v_d [STAGES];
   logic             v_q [STAGES];
   logic [WIDTH-1:0] res_d, res_q;
   logic             ovf_d, ovf_q;
   logic             a_msb;

   assign en       = !v_q[STAGES-1] || out_ready;
   assign in_ready = en;

   assign a_i[0] = a;
   assign b_i[0] = (sub == ADD_MODE_ADD) ? b : ~b;
   assign s_i[0] = '0;
   assign c_i[0] = (sub == ADD_MODE_SUB) ? ~cin : cin;
   assign v_i[0] = in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SEG;
      if (k > 0) begin : g_link
         assign a_i[k] = a_q[k-1];
         assign b_i[k] = b_q[k-1];
         assign s_i[k] = s_q[k-1];
         assign c_i[k] = c_q[k-1];
         assign v_i[k] = v_q[k-1];
      end
      if (LO < WIDTH) begin : g_add
         localparam int SW = (LO + SEG > WIDTH) ? WIDTH - LO : SEG;
         localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << LO;
         logic [SW-1:0] seg_s;
         adder_segment #(.W(SW)) u_seg (
            .a    (a_i[k][LO +: SW]),
            .b    (b_i[k][LO +: SW]),
            .cin  (c_i[k]),
            .s    (seg_s),
            .cout (c_d[k])
         );
         assign s_d[k] = (s_i[k] & ~MASK) | (WIDTH'(seg_s) << LO);
      end else begin : g_pass
         assign s_d[k] = s_i[k];
         assign c_d[k] = c_i[k];
      end
      assign a_d[k] = a_i[k];
      assign b_d[k] = b_i[k];
      assign v_d[k] = v_i[k];
   end

   // trailing empty stages pass operands unchanged, so the MSBs are final here
   always_comb begin
      a_msb = a_d[STAGES-1][WIDTH-1];
      ovf_d = (a_msb == b_d[STAGES-1][WIDTH-1]) && (s_d[STAGES-1][WIDTH-1] != a_msb);
`ifdef ADDER_PIPE_SAT_EN
      res_d = ovf_d ? {a_msb, {(WIDTH-1){~a_msb}}} : s_d[STAGES-1];
`else
      res_d = s_d[STAGES-1];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            s_q[i] <= '0;
            c_q[i] <= 1'b0;
            v_q[i] <= 1'b0;
         end
         res_q <= '0;
         ovf_q <= 1'b0;
      end else if (en) begin
         a_q   <= a_d;
         b_q   <= b_d;
         s_q   <= s_d;
         c_q   <= c_d;
         v_q   <= v_d;
         res_q <= res_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign s         = res_q;
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_adder_pipe_param.sv
// tb_adder_pipe_param: scoreboarded bench for adder_pipe_param at 16/2, 9/4 and 16/1
module tb_adder_pipe_param;
   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

`ifdef ADDER_PIPE_SAT_EN
   localparam logic [15:0] OVF_S = 16'h7FFF;
`else
   localparam logic [15:0] OVF_S = 16'h8000;
`endif
   localparam int W [3] = '{16, 9, 16};

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic ir16, ov16, co16, of16, ir9, ov9, co9, of9, ir1, ov1, co1, of1;
   logic [15:0] s16, s1;
   logic [8:0]  s9;
   int n_chk = 0, n_pass = 0;
   logic [17:0] res [3];
   logic        ov [3];
   logic        ir [3];
   logic [17:0] sbq [3][$];
   logic [17:0] held [3];
   logic        stall_p [3] = '{1'b0, 1'b0, 1'b0};
   logic [15:0] got16 [$];
   vec_t        lit [5];

   always #5 clk = ~clk;

   adder_pipe_param #(.WIDTH(16), .STAGES(2)) u16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .s(s16), .cout(co16), .ovf(of16));
   adder_pipe_param #(.WIDTH(9), .STAGES(4)) u9 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir9), .a(a[8:0]), .b(b[8:0]),
      .cin(cin), .sub(sub), .out_valid(ov9), .out_ready(out_ready), .s(s9), .cout(co9), .ovf(of9));
   adder_pipe_param #(.WIDTH(16), .STAGES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(co1), .ovf(of1));

   assign res[0] = {of16, co16, s16};
   assign res[1] = {of9, co9, 7'd0, s9};
   assign res[2] = {of1, co1, s1};
   assign ov[0] = ov16;
   assign ov[1] = ov9;
   assign ov[2] = ov1;
   assign ir[0] = ir16;
   assign ir[1] = ir9;
   assign ir[2] = ir1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // result of a +/- b on w bits from plain integer arithmetic: {ovf, cout, s}
   function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic sb);
      longint one_w = longint'(1) << w;
      longint mask = one_w - 1;
      longint half = one_w >> 1;
      longint ux = longint'(x) & mask;
      longint uy = longint'(y) & mask;
      longint c = longint'(ci);
      longint sx = (ux >= half) ? ux - one_w : ux;
      longint sy = (uy >= half) ? uy - one_w : uy;
      longint r = sb ? ux - uy - c : ux + uy + c;
      longint sr = sb ? sx - sy - c : sx + sy + c;
      logic co = sb ? (r >= 0) : (r >= one_w);
      logic ovf_m = (sr >= half) || (sr < -half);
      longint sv = r & mask;
`ifdef ADDER_PIPE_SAT_EN
      if (ovf_m) sv = (sx >= 0) ? half - 1 : half;
`endif
      return {ovf_m, co, 16'(sv)};
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(9))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'h00FF;
         5: return 16'h0100;
         6: return 16'h01FF;
         default: return 16'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            sbq[i].delete();
            stall_p[i] = 1'b0;
         end else begin
            if (stall_p[i]) chk($sformatf("u%0d hold", i), {ov[i], res[i]}, {1'b1, held[i]});
            chk($sformatf("u%0d in_ready", i), ir[i], !ov[i] || out_ready);
            if (ov[i] && out_ready) begin
               if (sbq[i].size() == 0) chk($sformatf("u%0d spurious out_valid", i), ov[i], 1'b0);
               else chk($sformatf("u%0d result", i), res[i], sbq[i].pop_front());
               if (i == 0) got16.push_back(s16);
            end
            if (in_valid && ir[i]) sbq[i].push_back(model(W[i], a, b, cin, sub));
            stall_p[i] = ov[i] && !out_ready;
            held[i] = res[i];
         end
      end
   end

   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
      logic acc;
      acc = 1'b0;
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk) acc = ir16;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("send accepted", acc, 1'b1);
   endtask

   task automatic op_lit(input vec_t v);
      send(v.a, v.b, v.cin, v.sub);
      @(negedge clk);
      chk($sformatf("lit %h/%h early valid", v.a, v.b), ov16, 1'b0);
      @(negedge clk);
      chk($sformatf("lit %h/%h valid", v.a, v.b), ov16, 1'b1);
      chk($sformatf("lit %h/%h result", v.a, v.b), {of16, co16, s16}, {v.ov, v.co, v.s});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      lit = '{
         '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0},
         '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
         '{16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_S,    1'b0, 1'b1},
         '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
         '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0}};
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", ov16, 1'b0);
      chk("reset s", s16, 16'h0000);
      chk("reset cout/ovf", {co16, of16}, 2'b00);
      chk("reset in_ready", ir16, 1'b1);
      chk("reset others valid", {ov9, ov1}, 2'b00);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) op_lit(lit[i]);

      send(16'h0011, 16'h0022, 1'b0, 1'b0);
      send(16'h0033, 16'h0044, 1'b0, 1'b0);
      rst = 1'b1; in_valid = 1'b1; a = 16'h0055; b = 16'h0066;
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("mid reset out_valid", ov16, 1'b0);
      chk("mid reset s", s16, 16'h0000);
      chk("mid reset cout/ovf", {co16, of16}, 2'b00);
      chk("mid reset in_ready", ir16, 1'b1);
      @(negedge clk);
      chk("reset beats in_valid", ov16, 1'b0);
      @(posedge clk);
      #1;
      op_lit('{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0});

      got16.delete();
      fork
         begin
            for (int i = 1; i <= 4; i++) send(16'(i), 16'(i), 1'b0, 1'b0);
         end
         begin
            int t;
            t = 0;
            while (!ov16 && t < 20) begin
               @(posedge clk);
               #1 t++;
            end
            chk("stall first valid", ov16, 1'b1);
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("stall in_ready", ir16, 1'b0);
               chk("stall s held", s16, 16'h0002);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      chk("stall count", got16.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("stall order %0d", i), (got16.size() > i) ? got16[i] : 16'hxxxx, 16'(2 * (i + 1)));

      for (int n = 0; n < 400; n++) begin
         in_valid = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         a = pick();
         b = pick();
         cin = 1'($urandom_range(1));
         sub = 1'($urandom_range(1));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("u%0d drained", i), sbq[i].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/adder_pipe_param.md
Name: adder_pipe_param

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the FMAC datapath; successor to the fixed 9-bit adder.
- The carry chain is split into STAGES segments, with a register between segments, so wide mantissa/exponent adds meet timing.
- Valid/ready handshake on both sides, full backpressure, add/sub mode and a signed-overflow flag.
- Sits between the multiplier partial-product stage and the accumulator normaliser.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range 2..64.
- STAGES, 2, number of carry-chain segments, equal to latency in cycles; legal range 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands are valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  mode: 0 computes a+b+cin, 1 computes a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  raw carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset (sync, active-high): all stage valids cleared; out_valid=0, s=0, cout=0, ovf=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: in-flight ops are discarded and never appear at the output. Reset has priority over a simultaneous in_valid.
- Operand conditioning at stage 0:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin, so sub=1 yields a + ~b + !cin = a - b - cin.
- Segmentation:
  - SEG = ceil(WIDTH/STAGES). Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1].
  - The last segment may be narrower. Empty trailing segments (when STAGES does not divide evenly) pass data through unchanged.
  - Stage k adds segment k and registers: the partial sum, the carry, and the not-yet-added upper operand bits (skew registers).
- Latency: exactly STAGES cycles from the accept edge to out_valid, provided no stall occurs. Throughput is 1 op/cycle.
- Handshake:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - Input is accepted when in_valid && in_ready.
  - When en=0 every stage holds (bubbles are not collapsed) and s/cout/ovf stay stable while out_valid=1.
  - Order is preserved and no op is lost or duplicated.
- cout: the carry out of the MSB. In sub mode cout=1 means no borrow.
- ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), computed on the final stage. It travels with the result.
- STAGES=1: a single registered adder with latency 1.
- STAGES=WIDTH: one bit per stage.

Optional Feature:
- Macro ADDER_PIPE_SAT_EN.
- Defined: on signed overflow, s saturates to 0 followed by all ones (max positive) if a[MSB]=0, else 1 followed by all zeros (min negative). ovf and cout still report the raw condition.
- Undefined: s wraps modulo 2^WIDTH. No saturation logic is synthesised.

Decomposition:
- Shared package/header fmac_pkg:
  - ADD_MODE_ADD=1'b0, ADD_MODE_SUB=1'b1.
  - A ceil-divide constant function used for SEG.
  - Legal-range limits for WIDTH/STAGES, checked by elaboration-time assertions.
- One sub-module, adder_segment: parametrised combinational ripple of full adders over SEG bits, with cin/cout. Instantiate it per stage via generate.
- Pipeline registers and handshake live in the top module.

Test Plan (WIDTH=16, STAGES=2 unless noted):
- a=0x00FF, b=0x0001, cin=0, sub=0 -> 2 cycles later out_valid=1, s=0x0100, cout=0, ovf=0 (carry crosses the segment boundary at bit 8).
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0, sub=0 -> s=0x8000, ovf=1. With ADDER_PIPE_SAT_EN: s=0x7FFF, ovf=1.
- a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0, ovf=0. Then a=0x0005, b=0x0003, cin=1, sub=1 -> s=0x0001, cout=1.
- Stall:
  - Stimulus: 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles starting at the first out_valid.
  - Required response: outputs 0x0002, 0x0004, 0x0006, 0x0008 appear in order with none lost. in_ready=0 and s held stable during the stall.
- Reset and parameter sweep:
  - Assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, s=0. A later op 0x0010+0x0020 returns 0x0030 after 2 cycles.
  - Repeat a random sweep at WIDTH=9 STAGES=4 and WIDTH=16 STAGES=1, scoreboarded against a behavioural a±b model.
